// File: rtl/neuron_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : neuron_cfg_sequencer
// Brief   : Framed, checksummed config loader for a spiking neuron, plus a
//           run enable and a divided delay tick for the delay lanes.
// Revision: 1.0 - initial release
// ============================================================================
module neuron_cfg_sequencer #(
   parameter int M         = 2,
   parameter int DELAY_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run_en,
   input  logic             cfg_valid,
   input  logic [7:0]       cfg_data,
   output logic             cfg_ready,
   output logic             cfg_done,
   output logic             cfg_error,
   output logic [M*8-1:0]   weights,
   output logic [7:0]       threshold,
   output logic [7:0]       decay,
   output logic [7:0]       refractory_period,
   output logic [M*3-1:0]   delay_values,
   output logic [M-1:0]     delays,
   output logic             enable,
   output logic             delay_clk
);

   localparam int               c_p        = 2*M + 3;
   localparam int               c_cnt_w    = $clog2(c_p + 1);
   localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(c_p - 1);
   localparam logic [7:0]       c_header   = 8'hA5;
   localparam logic [7:0]       c_div_last = 8'(DELAY_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PAYLOAD = 2'd1,
      S_CHECK   = 2'd2,
      S_COMMIT  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 w_accept;
   logic [c_cnt_w-1:0]   r_byte_cnt;
   logic [7:0]           r_csum;
   logic [7:0]           r_shadow [c_p];
   logic                 r_loaded;
   logic                 r_done;
   logic                 r_error;
   logic [M*8-1:0]       r_weights;
   logic [7:0]           r_threshold;
   logic [7:0]           r_decay;
   logic [7:0]           r_refractory;
   logic [M*3-1:0]       r_delay_values;
   logic [M-1:0]         r_delays;
   logic                 r_enable;
   logic                 w_enable_next;
   logic [7:0]           r_tick;
   logic                 r_delay_clk;

   assign w_accept      = cfg_valid & cfg_ready;
   assign w_enable_next = run_en & r_loaded;

   always_comb begin
      w_next    = r_state;
      cfg_ready = (r_state != S_COMMIT);
      case (r_state)
         S_IDLE:    if (w_accept && cfg_data == c_header) w_next = S_PAYLOAD;
         S_PAYLOAD: if (w_accept && r_byte_cnt == c_last) w_next = S_CHECK;
         S_CHECK:   if (w_accept) w_next = (cfg_data == r_csum) ? S_COMMIT : S_IDLE;
         S_COMMIT:  w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Frame capture: shadow bank and running checksum
   always_ff @(posedge clk) begin
      if (reset) begin
         r_byte_cnt <= '0;
         r_csum     <= '0;
         r_error    <= 1'b0;
         for (int i = 0; i < c_p; i++) r_shadow[i] <= '0;
      end else begin
         r_error <= 1'b0;
         if (r_state == S_IDLE && w_accept && cfg_data == c_header) begin
            r_byte_cnt <= '0;
            r_csum     <= '0;
         end else if (r_state == S_PAYLOAD && w_accept) begin
            r_shadow[r_byte_cnt] <= cfg_data;
            r_csum               <= r_csum ^ cfg_data;
            r_byte_cnt           <= r_byte_cnt + 1'b1;
         end else if (r_state == S_CHECK && w_accept && cfg_data != r_csum) begin
            r_error <= 1'b1;
         end
      end
   end

   // Atomic load of every active parameter on the closing edge of COMMIT
   always_ff @(posedge clk) begin
      if (reset) begin
         r_weights      <= '0;
         r_threshold    <= 8'hFF;
         r_decay        <= '0;
         r_refractory   <= '0;
         r_delay_values <= '0;
         r_delays       <= '0;
         r_loaded       <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_done <= (r_state == S_COMMIT);
         if (r_state == S_COMMIT) begin
            for (int i = 0; i < M; i++) begin
               r_weights[i*8 +: 8]      <= r_shadow[i];
               r_delay_values[i*3 +: 3] <= r_shadow[M+3+i][2:0];
               r_delays[i]              <= r_shadow[M+3+i][3];
            end
            r_threshold  <= r_shadow[M];
            r_decay      <= r_shadow[M+1];
            r_refractory <= r_shadow[M+2];
            r_loaded     <= 1'b1;
         end
      end
   end

   // Tick counter is cleared on the edge enable falls so delay_clk drops with it
   always_ff @(posedge clk) begin
      if (reset) begin
         r_enable    <= 1'b0;
         r_tick      <= '0;
         r_delay_clk <= 1'b0;
      end else begin
         r_enable <= w_enable_next;
         if (!r_enable || !w_enable_next) begin
            r_tick      <= '0;
            r_delay_clk <= 1'b0;
         end else if (r_tick == c_div_last) begin
            r_tick      <= '0;
            r_delay_clk <= 1'b1;
         end else begin
            r_tick      <= r_tick + 8'd1;
            r_delay_clk <= 1'b0;
         end
      end
   end

   assign cfg_done          = r_done;
   assign cfg_error         = r_error;
   assign weights           = r_weights;
   assign threshold         = r_threshold;
   assign decay             = r_decay;
   assign refractory_period = r_refractory;
   assign delay_values      = r_delay_values;
   assign delays            = r_delays;
   assign enable            = r_enable;
   assign delay_clk         = r_delay_clk;

endmodule
`default_nettype wire

// File: tb/tb_neuron_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_neuron_cfg_sequencer
// Brief   : Scoreboard bench for neuron_cfg_sequencer (M=2, DELAY_DIV=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_neuron_cfg_sequencer;

   localparam int M         = 2;
   localparam int DELAY_DIV = 4;

   typedef struct packed {
      logic [15:0] w;
      logic [7:0]  thr;
      logic [7:0]  dec;
      logic [7:0]  rfp;
      logic [5:0]  dv;
      logic [1:0]  dl;
   } params_t;

   typedef struct {
      logic    err;
      params_t p;
      params_t o;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             run_en;
   logic             cfg_valid;
   logic [7:0]       cfg_data;
   logic             cfg_ready;
   logic             cfg_done;
   logic             cfg_error;
   logic [M*8-1:0]   weights;
   logic [7:0]       threshold;
   logic [7:0]       decay;
   logic [7:0]       refractory_period;
   logic [M*3-1:0]   delay_values;
   logic [M-1:0]     delays;
   logic             enable;
   logic             delay_clk;

   neuron_cfg_sequencer #(.M(M), .DELAY_DIV(DELAY_DIV)) dut (
      .clk               (clk),
      .reset             (reset),
      .run_en            (run_en),
      .cfg_valid         (cfg_valid),
      .cfg_data          (cfg_data),
      .cfg_ready         (cfg_ready),
      .cfg_done          (cfg_done),
      .cfg_error         (cfg_error),
      .weights           (weights),
      .threshold         (threshold),
      .decay             (decay),
      .refractory_period (refractory_period),
      .delay_values      (delay_values),
      .delays            (delays),
      .enable            (enable),
      .delay_clk         (delay_clk)
   );

   always #5 clk = ~clk;

   localparam params_t c_reset_p = '{w: 16'h0000, thr: 8'hFF, dec: 8'h00, rfp: 8'h00, dv: 6'b000000, dl: 2'b00};
   localparam params_t c_frame_a = '{w: 16'h2010, thr: 8'h30, dec: 8'h01, rfp: 8'h05, dv: 6'b010011, dl: 2'b01};

   int      n_checks = 0;
   int      n_fail   = 0;
   exp_t    sb[$];
   params_t cur_p;
   params_t prev_p;
   params_t model_p;
   int      cyc      = 0;
   int      ready_lo = 0;
   int      last_dclk = 0;
   bit      dclk_v   = 1'b0;

   assign cur_p = {weights, threshold, decay, refractory_period, delay_values, delays};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] f [9]);
      logic [7:0] s = 8'h00;
      for (int i = 1; i < 8; i++) s = s ^ f[i];
      return s;
   endfunction

   function automatic params_t decode(input logic [7:0] f [9]);
      params_t p;
      p.w   = {f[2], f[1]};
      p.thr = f[3];
      p.dec = f[4];
      p.rfp = f[5];
      p.dv  = {f[7][2:0], f[6][2:0]};
      p.dl  = {f[7][3], f[6][3]};
      return p;
   endfunction

   // Response monitor: pops the scoreboard on every cfg_done / cfg_error pulse
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset) begin
         dclk_v = 1'b0;
      end else begin
         if (!cfg_ready) ready_lo++;
         if (cfg_done || cfg_error) begin
            if (sb.size() == 0) begin
               check_val("unexpected_resp", 64'({cfg_done, cfg_error}), 64'(0));
            end else begin
               e = sb.pop_front();
               check_val("resp_kind", 64'({cfg_done, cfg_error}), 64'({~e.err, e.err}));
               check_val("params_after", 64'(cur_p), 64'(e.p));
               check_val("params_before", 64'(prev_p), 64'(e.o));
            end
         end
         if (!enable) begin
            if (delay_clk) check_val("dclk_while_off", 64'(delay_clk), 64'(0));
            dclk_v = 1'b0;
         end else if (delay_clk) begin
            if (dclk_v) check_val("dclk_period", 64'(cyc - last_dclk), 64'(DELAY_DIV));
            last_dclk = cyc;
            dclk_v    = 1'b1;
         end
      end
      prev_p = cur_p;
   end

   task automatic send_byte(input logic [7:0] b);
      bit rdy;
      int guard = 0;
      cfg_valid = 1'b1;
      cfg_data  = b;
      do begin
         @(negedge clk);
         rdy = cfg_ready;
         @(posedge clk);
         #1;
         guard++;
      end while (!rdy && guard < 20);
      if (!rdy) check_val("ready_timeout", 64'(rdy), 64'(1));
      cfg_valid = 1'b0;
   endtask

   task automatic wait_sb();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check_val("sb_drain", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [7:0] f [9], input int gap, input logic err,
                            input params_t p, input int exp_lo);
      exp_t e;
      int   lo0;
      e.err = err;
      e.o   = model_p;
      e.p   = err ? model_p : p;
      sb.push_back(e);
      if (!err) model_p = p;
      lo0 = ready_lo;
      for (int i = 0; i < 9; i++) begin
         send_byte(f[i]);
         if (gap > 0 && i < 8) repeat (gap) begin @(posedge clk); #1; end
      end
      wait_sb();
      check_val("ready_low_cycles", 64'(ready_lo - lo0), 64'(exp_lo));
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      cfg_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      model_p = c_reset_p;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fa  [9] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h01, 8'h05, 8'h0B, 8'h82, 8'h8D};
      logic [7:0] fab [9] = '{8'hA5, 8'h10, 8'h20, 8'h30, 8'h01, 8'h05, 8'h0B, 8'h82, 8'h8C};
      logic [7:0] fb  [9] = '{8'hA5, 8'h11, 8'h22, 8'h44, 8'h02, 8'h03, 8'h0C, 8'hF5, 8'h00};
      params_t    pb;
      fb[8] = xsum(fb);
      pb    = decode(fb);

      reset = 1'b1; run_en = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
      model_p = c_reset_p;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check_val("reset_params", 64'(cur_p), 64'(c_reset_p));
      check_val("reset_ctrl", 64'({cfg_ready, cfg_done, cfg_error, enable, delay_clk}), 64'(5'b10000));
      @(posedge clk); #1;

      // Bad checksum: error, nothing loaded, run_en has no effect
      run_frame(fab, 0, 1'b1, c_reset_p, 0);
      run_en = 1'b1;
      repeat (8) @(negedge clk);
      check_val("enable_unloaded", 64'(enable), 64'(0));
      @(posedge clk); #1 run_en = 1'b0;

      // Good frame A
      run_frame(fa, 0, 1'b0, c_frame_a, 1);

      // Run: enable lags run_en by one cycle, delay_clk every DELAY_DIV cycles
      run_en = 1'b1;
      @(negedge clk);
      check_val("enable_lag", 64'(enable), 64'(0));
      for (int k = 0; k <= 12; k++) begin
         @(negedge clk);
         if (k == 0) check_val("enable_rise", 64'(enable), 64'(1));
         check_val($sformatf("dclk_k%0d", k), 64'(delay_clk),
                   64'((k > 0 && k % DELAY_DIV == 0) ? 1 : 0));
      end
      @(posedge clk); #1;

      // Second frame while running
      run_frame(fb, 0, 1'b0, pb, 1);
      check_val("enable_kept", 64'(enable), 64'(1));
      run_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("enable_fall", 64'({enable, delay_clk}), 64'(0));
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_val("dclk_off", 64'(delay_clk), 64'(0));
      end
      @(posedge clk); #1;

      // Garbage before header, gaps between bytes
      send_byte(8'h00);
      send_byte(8'hFF);
      run_frame(fa, 3, 1'b0, c_frame_a, 1);

      // Reset mid-frame, then a full frame
      for (int i = 0; i < 5; i++) send_byte(fb[i]);
      do_reset();
      @(negedge clk);
      check_val("ready_after_reset", 64'(cfg_ready), 64'(1));
      check_val("params_after_reset", 64'(cur_p), 64'(c_reset_p));
      @(posedge clk); #1;
      run_frame(fa, 0, 1'b0, c_frame_a, 1);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/neuron_cfg_sequencer.md
NEURON_CFG_SEQUENCER -- requirements
Module: neuron_cfg_sequencer

Interface
REQ-001 SHALL have parameter M, default 2: number of neuron inputs (weights and delay lanes).
REQ-002 SHALL have parameter DELAY_DIV, default 4, legal range 2..255: clk cycles per delay_clk tick.
REQ-003 SHALL have port clk  input  1: the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port run_en  input  1: host request to run the neuron.
REQ-006 SHALL have port cfg_valid  input  1: config byte valid.
REQ-007 SHALL have port cfg_data  input  8: config byte.
REQ-008 SHALL have port cfg_ready  output  1: sequencer accepts a byte this cycle.
REQ-009 SHALL have port cfg_done  output  1: one-cycle pulse after a successful commit.
REQ-010 SHALL have port cfg_error  output  1: one-cycle pulse on checksum mismatch.
REQ-011 SHALL have ports weights  output  M*8, threshold  output  8, decay  output  8, refractory_period  output  8: active neuron parameters.
REQ-012 SHALL have ports delay_values  output  M*3, delays  output  M: active per-input delay value and delay enable.
REQ-013 SHALL have port enable  output  1: neuron enable.
REQ-014 SHALL have port delay_clk  output  1: delay tick for the delay lanes.

Function
REQ-015 SHALL transfer a byte only on a clk edge where cfg_valid and cfg_ready are both high.
REQ-016 SHALL implement the states IDLE, PAYLOAD, CHECK and COMMIT.
REQ-017 SHALL drive cfg_ready combinationally: 1 in IDLE, PAYLOAD and CHECK; 0 in COMMIT.
REQ-018 IDLE SHALL go to PAYLOAD when the accepted byte is 0xA5; any other accepted byte SHALL be dropped, and the state SHALL remain IDLE.
REQ-019 The frame payload SHALL be P = 2M+3 bytes, in order: weight[0..M-1], threshold, decay, refractory_period, dly[0..M-1].
REQ-020 For each dly[i] byte, bit3 SHALL be delays[i], bits2:0 SHALL be delay_values[i*3+:3], and bits7:4 SHALL be ignored.
REQ-021 weight[i] SHALL map to weights[i*8+:8].
REQ-022 PAYLOAD SHALL write each accepted byte into a shadow register bank and XOR it into an 8-bit running checksum, which is cleared on header accept.
REQ-023 A payload byte counter SHALL move the state to CHECK after the P-th accepted byte.
REQ-024 In CHECK, an accepted byte equal to the running checksum SHALL move the state to COMMIT.
REQ-025 In CHECK, an accepted byte not equal to the running checksum SHALL return the state to IDLE and pulse cfg_error one cycle later.
REQ-026 On a checksum mismatch, the active parameters SHALL NOT change.
REQ-027 COMMIT SHALL last exactly one cycle; at its closing edge, all active parameters SHALL load from the shadow bank atomically, cfg_done SHALL rise for one cycle, a sticky loaded flag SHALL set, and the state SHALL return to IDLE.
REQ-028 Active parameters SHALL never show a partially loaded frame.
REQ-029 A commit while enable=1 SHALL NOT disturb enable or the delay_clk phase.
REQ-030 A 0xA5 byte inside PAYLOAD SHALL be treated as data, not as a restart.
REQ-031 enable SHALL be registered and equal to run_en AND loaded, delayed by one cycle.
REQ-032 An 8-bit tick counter SHALL run only while enable=1 and SHALL be held at 0 while enable=0.
REQ-033 delay_clk SHALL be registered and high for one clk cycle each time the tick counter reaches DELAY_DIV-1; the counter SHALL then wrap to 0.
REQ-034 The first delay_clk pulse SHALL occur DELAY_DIV cycles after enable rises.
REQ-035 delay_clk SHALL be 0 whenever enable=0.

Reset
REQ-036 While reset is high at a clk edge: state SHALL be IDLE; the counters, checksum, shadow bank and loaded flag SHALL be 0.
REQ-037 Reset values SHALL be: weights=0, threshold=0xFF, decay=0, refractory_period=0, delay_values=0, delays=0, enable=0, delay_clk=0, cfg_done=0, cfg_error=0.
REQ-038 Reset asserted mid-frame SHALL abandon the frame; cfg_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-039 Bench SHALL cover (M=2): frame A5,10,20,30,01,05,0B,82,8D -> weights=0x2010, threshold=0x30, decay=0x01, refractory_period=0x05, delay_values=6'b010011, delays=2'b01; cfg_done pulses once; cfg_ready=0 for exactly one cycle.
REQ-040 Bench SHALL cover: the same frame with checksum 0x8C -> cfg_error pulses once; all parameters keep their reset values; loaded stays 0, so run_en=1 leaves enable=0.
REQ-041 Bench SHALL cover: bytes 00,FF before the header, plus cfg_valid gaps of 3 cycles between payload bytes -> result identical to the first scenario.
REQ-042 Bench SHALL cover: after a commit, run_en=1 -> enable rises 1 cycle later, then delay_clk pulses at enable-relative cycles 4, 8, 12 (DELAY_DIV=4); run_en=0 -> enable and delay_clk fall to 0.
REQ-043 Bench SHALL cover: reset asserted after the 4th payload byte, then a new full frame -> the first partial frame has no effect; the second frame commits correctly.
REQ-044 Bench SHALL cover: a second valid frame while running -> parameters switch in a single cycle; the delay_clk period is uninterrupted.
